// File: rtl/ps2_zx_keyboard_pkg.sv
// Shared decoder types, scancode constants and the set-2 keymap lookup for ps2_zx_keyboard.
// Extended-key positions and map_ext() exist only when PS2_KEYMAP_EXT_EN is defined.
package ps2_zx_keyboard_pkg;

  localparam int MX_ROWS = 8;
  localparam int MX_COLS = 5;
  localparam int MX_KEYS = MX_ROWS * MX_COLS;

  localparam logic [7:0] SC_PFX_EXT = 8'hE0;
  localparam logic [7:0] SC_PFX_BRK = 8'hF0;
  localparam logic [7:0] SC_BAT     = 8'hAA;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_OVR_LO  = 8'h00;
  localparam logic [7:0] SC_OVR_HI  = 8'hFF;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_DEL     = 8'h71;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_BKSP    = 8'h66;

  typedef logic [5:0] key_pos_t;

  // Matrix bit index is row*MX_COLS + column.
  localparam key_pos_t POS_CS = 6'd0;
  localparam key_pos_t POS_0  = 6'd20;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic     hit0;
    key_pos_t pos0;
    logic     hit1;
    key_pos_t pos1;
  } key_hit_t;

  function automatic key_hit_t one_key(input int r, input int c);
    key_hit_t h;
    h      = '0;
    h.hit0 = 1'b1;
    h.pos0 = key_pos_t'(r * MX_COLS + c);
    return h;
  endfunction

  function automatic key_hit_t two_keys(input key_pos_t a, input key_pos_t b);
    key_hit_t h;
    h.hit0 = 1'b1;
    h.pos0 = a;
    h.hit1 = 1'b1;
    h.pos1 = b;
    return h;
  endfunction

  function automatic key_hit_t map_std(input logic [7:0] code);
    key_hit_t h;
    case (code)
      8'h12: h = one_key(0, 0);
      8'h1A: h = one_key(0, 1);
      8'h22: h = one_key(0, 2);
      8'h21: h = one_key(0, 3);
      8'h2A: h = one_key(0, 4);
      8'h1C: h = one_key(1, 0);
      8'h1B: h = one_key(1, 1);
      8'h23: h = one_key(1, 2);
      8'h2B: h = one_key(1, 3);
      8'h34: h = one_key(1, 4);
      8'h15: h = one_key(2, 0);
      8'h1D: h = one_key(2, 1);
      8'h24: h = one_key(2, 2);
      8'h2D: h = one_key(2, 3);
      8'h2C: h = one_key(2, 4);
      8'h16: h = one_key(3, 0);
      8'h1E: h = one_key(3, 1);
      8'h26: h = one_key(3, 2);
      8'h25: h = one_key(3, 3);
      8'h2E: h = one_key(3, 4);
      8'h45: h = one_key(4, 0);
      8'h46: h = one_key(4, 1);
      8'h3E: h = one_key(4, 2);
      8'h3D: h = one_key(4, 3);
      8'h36: h = one_key(4, 4);
      8'h4D: h = one_key(5, 0);
      8'h44: h = one_key(5, 1);
      8'h43: h = one_key(5, 2);
      8'h3C: h = one_key(5, 3);
      8'h35: h = one_key(5, 4);
      8'h5A: h = one_key(6, 0);
      8'h4B: h = one_key(6, 1);
      8'h42: h = one_key(6, 2);
      8'h3B: h = one_key(6, 3);
      8'h33: h = one_key(6, 4);
      8'h29: h = one_key(7, 0);
      8'h14: h = one_key(7, 1);
      8'h3A: h = one_key(7, 2);
      8'h31: h = one_key(7, 3);
      8'h32: h = one_key(7, 4);
      SC_RSHIFT: h = one_key(0, 0);
      SC_BKSP:   h = two_keys(POS_CS, POS_0);
      default:   h = '0;
    endcase
    return h;
  endfunction

`ifdef PS2_KEYMAP_EXT_EN
  localparam key_pos_t POS_5     = 6'd19;
  localparam key_pos_t POS_6     = 6'd24;
  localparam key_pos_t POS_7     = 6'd23;
  localparam key_pos_t POS_8     = 6'd22;
  localparam key_pos_t POS_ENTER = 6'd30;

  // Cursor keys become CS plus the Spectrum cursor digit.
  function automatic key_hit_t map_ext(input logic [7:0] code);
    key_hit_t h;
    case (code)
      8'h6B:   h = two_keys(POS_CS, POS_5);
      8'h72:   h = two_keys(POS_CS, POS_6);
      8'h75:   h = two_keys(POS_CS, POS_7);
      8'h74:   h = two_keys(POS_CS, POS_8);
      8'h5A:   h = two_keys(POS_ENTER, POS_ENTER);
      default: h = '0;
    endcase
    return h;
  endfunction
`endif

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF synchronisers, stable-sample filters, 11-bit framing with odd
// parity check and a mid-frame idle timeout. Emits one-cycle byte_valid / err pulses.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FILTER_LEN-1:0] clk_hist_q, clk_hist_d, dat_hist_q, dat_hist_d;
  logic                  clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic                  clk_prev_q, clk_prev_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            shift_q, shift_d, byte_q, byte_d;
  logic                  par_q, par_d, valid_q, valid_d, err_q, err_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  fall;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    clk_hist_d = {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    dat_hist_d = {dat_hist_q[FILTER_LEN-2:0], dat_sync_q[1]};
    clk_filt_d = clk_filt_q;
    dat_filt_d = dat_filt_q;
    if (&clk_hist_q)       clk_filt_d = 1'b1;
    else if (~|clk_hist_q) clk_filt_d = 1'b0;
    if (&dat_hist_q)       dat_filt_d = 1'b1;
    else if (~|dat_hist_q) dat_filt_d = 1'b0;
    clk_prev_d = clk_filt_q;
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  // cnt_q counts bits already taken: 0 idle, 1..8 data, 9 parity, 10 awaiting stop.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    byte_d  = byte_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (cnt_q == 4'd0) begin
        if (!dat_filt_q) cnt_d = 4'd1;
        else             err_d = 1'b1;
      end else if (cnt_q <= 4'd8) begin
        shift_d = {dat_filt_q, shift_q[7:1]};
        cnt_d   = cnt_q + 4'd1;
      end else if (cnt_q == 4'd9) begin
        par_d = dat_filt_q;
        cnt_d = 4'd10;
      end else begin
        cnt_d = 4'd0;
        if (dat_filt_q && (^{shift_q, par_q})) begin
          valid_d = 1'b1;
          byte_d  = shift_q;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (cnt_q != 4'd0) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d = '0;
        cnt_d = 4'd0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_hist_q <= '1;
      dat_hist_q <= '1;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      byte_q     <= 8'h00;
      tmo_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_hist_q <= clk_hist_d;
      dat_hist_q <= dat_hist_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_prev_q <= clk_prev_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      byte_q     <= byte_d;
      tmo_q      <= tmo_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign data_byte  = byte_q;
  assign byte_valid = valid_q;
  assign err        = err_q;
endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix: prefix decoder, matrix state, row readout
// and Ctrl+Alt+Del reset request. Define PS2_KEYMAP_EXT_EN to map cursor keys and keypad Enter.
import ps2_zx_keyboard_pkg::*;

module ps2_zx_keyboard #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] row_addr,
  output logic [4:0] kd,
  output logic       n_key_rst,
  output logic       frame_err
);
  logic [7:0]         rx_byte;
  logic               rx_valid;
  dec_state_e         state_q, state_d;
  logic               is_overrun;
  logic               do_clear, do_apply, apply_make, apply_ext;
  key_hit_t           hit;
  logic [MX_KEYS-1:0] matrix_q, matrix_d;
  logic               ctrl_q, ctrl_d, alt_q, alt_d, del_q, del_d;
  logic [4:0]         kd_q, kd_d;
  logic               n_key_rst_q, n_key_rst_d;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk14(clk14),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .data_byte(rx_byte),
    .byte_valid(rx_valid),
    .err(frame_err)
  );

  assign is_overrun = (rx_byte == SC_OVR_LO) || (rx_byte == SC_OVR_HI);

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) state_q <= DEC_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      if (is_overrun) begin
        state_d = DEC_IDLE;
      end else begin
        unique case (state_q)
          DEC_IDLE: begin
            if (rx_byte == SC_PFX_BRK)      state_d = DEC_BRK;
            else if (rx_byte == SC_PFX_EXT) state_d = DEC_EXT;
          end
          DEC_EXT: state_d = (rx_byte == SC_PFX_BRK) ? DEC_EXT_BRK : DEC_IDLE;
          default: state_d = DEC_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    do_clear   = 1'b0;
    do_apply   = 1'b0;
    apply_make = 1'b0;
    apply_ext  = 1'b0;
    if (rx_valid) begin
      if (is_overrun) begin
        do_clear = 1'b1;
      end else begin
        unique case (state_q)
          DEC_IDLE: begin
            if (rx_byte != SC_PFX_BRK && rx_byte != SC_PFX_EXT &&
                rx_byte != SC_BAT && rx_byte != SC_ACK) begin
              do_apply   = 1'b1;
              apply_make = 1'b1;
            end
          end
          DEC_EXT: begin
            if (rx_byte != SC_PFX_BRK) begin
              do_apply   = 1'b1;
              apply_make = 1'b1;
              apply_ext  = 1'b1;
            end
          end
          DEC_BRK: do_apply = 1'b1;
          DEC_EXT_BRK: begin
            do_apply  = 1'b1;
            apply_ext = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    if (apply_ext) begin
`ifdef PS2_KEYMAP_EXT_EN
      hit = map_ext(rx_byte);
`else
      hit = '0;
`endif
    end else begin
      hit = map_std(rx_byte);
    end
  end

  // Overrun clear outranks any make/release decoded in the same cycle.
  always_comb begin
    matrix_d = matrix_q;
    ctrl_d   = ctrl_q;
    alt_d    = alt_q;
    del_d    = del_q;
    if (do_clear) begin
      matrix_d = '0;
      ctrl_d   = 1'b0;
      alt_d    = 1'b0;
      del_d    = 1'b0;
    end else if (do_apply) begin
      if (hit.hit0) matrix_d[hit.pos0] = apply_make;
      if (hit.hit1) matrix_d[hit.pos1] = apply_make;
      if (!apply_ext && rx_byte == SC_CTRL) ctrl_d = apply_make;
      if (!apply_ext && rx_byte == SC_ALT)  alt_d  = apply_make;
      if (apply_ext && rx_byte == SC_DEL)   del_d  = apply_make;
    end
  end

  always_comb begin
    kd_d = 5'b11111;
    for (int r = 0; r < MX_ROWS; r++) begin
      if (!row_addr[r]) kd_d = kd_d & ~matrix_q[r*MX_COLS +: MX_COLS];
    end
    n_key_rst_d = ~(ctrl_q & alt_q & del_q);
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      matrix_q    <= '0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      del_q       <= 1'b0;
      kd_q        <= 5'b11111;
      n_key_rst_q <= 1'b1;
    end else begin
      matrix_q    <= matrix_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      del_q       <= del_d;
      kd_q        <= kd_d;
      n_key_rst_q <= n_key_rst_d;
    end
  end

  assign kd        = kd_q;
  assign n_key_rst = n_key_rst_q;
endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Self-checking bench for ps2_zx_keyboard: directed scenarios plus randomized key traffic
// checked against a scancode-level reference model of the keyboard matrix.
`timescale 1ns/1ps
module tb_ps2_zx_keyboard;
  localparam int HALF = 12;
  localparam int TMO  = 14000;

  logic       clk14 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] row_addr = 8'hFF;
  logic [4:0] kd;
  logic       n_key_rst;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  // Keymap as written in the key table: [row][column].
  logic [7:0] std_tbl [0:7][0:4] = '{
    '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}};
  logic [7:0] misc_pool [0:2] = '{8'h59, 8'h66, 8'h11};
  logic [7:0] ext_pool  [0:6] = '{8'h71, 8'h6B, 8'h72, 8'h75, 8'h74, 8'h5A, 8'h14};

  bit m_key [0:7][0:4];
  bit m_ext, m_brk, m_ctrl, m_alt, m_del;

  ps2_zx_keyboard dut (
    .clk14(clk14),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .row_addr(row_addr),
    .kd(kd),
    .n_key_rst(n_key_rst),
    .frame_err(frame_err)
  );

  always #35 clk14 = ~clk14;

  always @(negedge clk14) if (frame_err === 1'b1) err_pulses++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk14);
    #1;
  endtask

  task automatic model_reset;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) m_key[r][c] = 1'b0;
    m_ext = 0; m_brk = 0; m_ctrl = 0; m_alt = 0; m_del = 0;
  endtask

  task automatic model_apply(input logic [7:0] code, input bit ext, input bit make);
    if (!ext) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          if (std_tbl[r][c] == code) m_key[r][c] = make;
      if (code == 8'h59) m_key[0][0] = make;
      if (code == 8'h66) begin m_key[0][0] = make; m_key[4][0] = make; end
      if (code == 8'h14) m_ctrl = make;
      if (code == 8'h11) m_alt = make;
    end else begin
      if (code == 8'h71) m_del = make;
`ifdef PS2_KEYMAP_EXT_EN
      case (code)
        8'h6B: begin m_key[0][0] = make; m_key[3][4] = make; end
        8'h72: begin m_key[0][0] = make; m_key[4][4] = make; end
        8'h75: begin m_key[0][0] = make; m_key[4][3] = make; end
        8'h74: begin m_key[0][0] = make; m_key[4][2] = make; end
        8'h5A: m_key[6][0] = make;
        default: ;
      endcase
`endif
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h00 || b == 8'hFF) begin
      for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) m_key[r][c] = 1'b0;
      m_ext = 0; m_brk = 0;
    end else if (m_brk) begin
      model_apply(b, m_ext, 1'b0);
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0 && !m_ext) begin
      m_ext = 1;
    end else if (!m_ext && (b == 8'hAA || b == 8'hFA)) begin
      m_ext = 0;
    end else begin
      model_apply(b, m_ext, 1'b1);
      m_ext = 0;
    end
  endtask

  function automatic logic [4:0] model_kd(input logic [7:0] ra);
    logic [4:0] k;
    k = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!ra[r] && m_key[r][c]) k[c] = 1'b0;
    return k;
  endfunction

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    cyc(2 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic set_row(input logic [7:0] ra);
    row_addr = ra;
    cyc(2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(5);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL reset_kd got=%b exp=11111", kd); end
    checks++; if (n_key_rst !== 1'b1) begin failures++; $display("FAIL reset_nkr got=%b exp=1", n_key_rst); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    model_reset();
    cyc(5);
    set_row(8'h00);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL reset_all_rows got=%b exp=11111", kd); end
    set_row(8'hFF);
  endtask

  task automatic test_make_break;
    send_byte(8'h1C);
    set_row(8'hFD);
    checks++; if (kd !== 5'b11110) begin failures++; $display("FAIL a_make got=%b exp=11110", kd); end
    set_row(8'hFE);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL a_other_row got=%b exp=11111", kd); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    set_row(8'hFD);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL a_break got=%b exp=11111", kd); end
  endtask

  task automatic test_backspace;
    logic [7:0] rows [0:2] = '{8'hFE, 8'hEF, 8'hEE};
    send_byte(8'h66);
    for (int i = 0; i < 3; i++) begin
      set_row(rows[i]);
      checks++; if (kd !== 5'b11110) begin failures++; $display("FAIL bksp_make row=%h got=%b exp=11110", rows[i], kd); end
    end
    send_byte(8'hF0);
    send_byte(8'h66);
    for (int i = 0; i < 2; i++) begin
      set_row(rows[i]);
      checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL bksp_break row=%h got=%b exp=11111", rows[i], kd); end
    end
  endtask

  task automatic test_parity;
    int e0;
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1);
    checks++; if (err_pulses - e0 !== 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", err_pulses - e0); end
    set_row(8'hFD);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL parity_matrix got=%b exp=11111", kd); end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_pulses;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    cyc(TMO + 300);
    checks++; if (err_pulses - e0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_pulses - e0); end
    send_byte(8'h29);
    set_row(8'h7F);
    checks++; if (kd !== 5'b11110) begin failures++; $display("FAIL timeout_space got=%b exp=11110", kd); end
    send_byte(8'hF0);
    send_byte(8'h29);
    set_row(8'h7F);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL timeout_space_rel got=%b exp=11111", kd); end
  endtask

  task automatic test_ctrl_alt_del;
    send_byte(8'h14);
    send_byte(8'h11);
    checks++; if (n_key_rst !== 1'b1) begin failures++; $display("FAIL cad_partial got=%b exp=1", n_key_rst); end
    send_byte(8'hE0);
    send_byte(8'h71);
    checks++; if (n_key_rst !== 1'b0) begin failures++; $display("FAIL cad_assert got=%b exp=0", n_key_rst); end
    set_row(8'h7F);
    checks++; if (kd !== 5'b11101) begin failures++; $display("FAIL cad_ss got=%b exp=11101", kd); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h71);
    checks++; if (n_key_rst !== 1'b1) begin failures++; $display("FAIL cad_del_rel got=%b exp=1", n_key_rst); end
    set_row(8'h7F);
    checks++; if (kd !== 5'b11101) begin failures++; $display("FAIL cad_ss_held got=%b exp=11101", kd); end
    send_byte(8'hE0);
    send_byte(8'h71);
    checks++; if (n_key_rst !== 1'b0) begin failures++; $display("FAIL cad_reassert got=%b exp=0", n_key_rst); end
    send_byte(8'hF0);
    send_byte(8'h14);
    checks++; if (n_key_rst !== 1'b1) begin failures++; $display("FAIL cad_ctrl_rel got=%b exp=1", n_key_rst); end
    send_byte(8'hF0);
    send_byte(8'h11);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h71);
    set_row(8'h7F);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL cad_all_rel got=%b exp=11111", kd); end
  endtask

  task automatic test_ext;
    logic [4:0] exp_fe, exp_f7;
`ifdef PS2_KEYMAP_EXT_EN
    exp_fe = 5'b11110;
    exp_f7 = 5'b01111;
`else
    exp_fe = 5'b11111;
    exp_f7 = 5'b11111;
`endif
    send_byte(8'hE0);
    send_byte(8'h6B);
    set_row(8'hFE);
    checks++; if (kd !== exp_fe) begin failures++; $display("FAIL ext_left_fe got=%b exp=%b", kd, exp_fe); end
    set_row(8'hF7);
    checks++; if (kd !== exp_f7) begin failures++; $display("FAIL ext_left_f7 got=%b exp=%b", kd, exp_f7); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    set_row(8'hF6);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL ext_left_rel got=%b exp=11111", kd); end
    send_byte(8'h1C);
    set_row(8'hFD);
    checks++; if (kd !== 5'b11110) begin failures++; $display("FAIL ext_then_std got=%b exp=11110", kd); end
    send_byte(8'hF0);
    send_byte(8'h1C);
  endtask

  task automatic test_overrun;
    send_byte(8'h1C);
    send_byte(8'h1A);
    set_row(8'hFC);
    checks++; if (kd !== 5'b11100) begin failures++; $display("FAIL ovr_pre got=%b exp=11100", kd); end
    send_byte(8'hFF);
    set_row(8'hFC);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL ovr_clear got=%b exp=11111", kd); end
    send_byte(8'hE0);
    send_byte(8'h00);
    send_byte(8'h1C);
    set_row(8'hFD);
    checks++; if (kd !== 5'b11110) begin failures++; $display("FAIL ovr_idle got=%b exp=11110", kd); end
    send_byte(8'hF0);
    send_byte(8'h1C);
  endtask

  task automatic test_reset_mid;
    send_byte(8'h1C);
    set_row(8'hFD);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    rst_n = 1'b0;
    cyc(3);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL rmid_kd got=%b exp=11111", kd); end
    checks++; if (n_key_rst !== 1'b1) begin failures++; $display("FAIL rmid_nkr got=%b exp=1", n_key_rst); end
    ps2_dat = 1'b1;
    rst_n = 1'b1;
    model_reset();
    cyc(20);
    set_row(8'hFD);
    checks++; if (kd !== 5'b11111) begin failures++; $display("FAIL rmid_cleared got=%b exp=11111", kd); end
    send_byte(8'h1C);
    set_row(8'hFD);
    checks++; if (kd !== 5'b11110) begin failures++; $display("FAIL rmid_newframe got=%b exp=11110", kd); end
    send_byte(8'hF0);
    send_byte(8'h1C);
  endtask

  task automatic test_random;
    int e0, kind, ri, ci;
    logic [7:0] code, ra;
    logic [4:0] exp_kd;
    bit ext, brk;
    e0 = err_pulses;
    for (int ev = 0; ev < 40; ev++) begin
      kind = int'($urandom_range(0, 9));
      brk  = bit'($urandom_range(0, 1));
      ext  = 1'b0;
      if (kind <= 5) begin
        ri = int'($urandom_range(0, 7));
        ci = int'($urandom_range(0, 4));
        code = std_tbl[ri][ci];
      end else if (kind == 6) begin
        ri = int'($urandom_range(0, 2));
        code = misc_pool[ri];
      end else if (kind == 7) begin
        ri = int'($urandom_range(0, 6));
        code = ext_pool[ri];
        ext = 1'b1;
      end else begin
        code = 8'($urandom_range(1, 254));
        brk = 1'b0;
      end
      if (ext) send_byte(8'hE0);
      if (brk) send_byte(8'hF0);
      send_byte(code);
      for (int k = 0; k < 2; k++) begin
        ra = 8'($urandom);
        set_row(ra);
        exp_kd = model_kd(ra);
        checks++; if (kd !== exp_kd) begin failures++; $display("FAIL rand_kd ev=%0d code=%h row=%h got=%b exp=%b", ev, code, ra, kd, exp_kd); end
      end
      checks++; if (n_key_rst !== ~(m_ctrl & m_alt & m_del)) begin failures++; $display("FAIL rand_nkr ev=%0d got=%b exp=%b", ev, n_key_rst, ~(m_ctrl & m_alt & m_del)); end
    end
    checks++; if (err_pulses - e0 !== 0) begin failures++; $display("FAIL rand_no_err got=%0d exp=0", err_pulses - e0); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_backspace();
    test_parity();
    test_timeout();
    test_ctrl_alt_del();
    test_ext();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
